pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 42 ++++
 rtl/pipe_ctrl_div_watchdog.sv | 31 +++
 rtl/pipe_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline hazard/divide controller.
//   - Stall-vector bit positions (pc, if, id, ex, mem, wb)
//   - Canned stall patterns for load-use and divide holds
//   - FSM state encoding
//   - Load-use hazard detect helper
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W  = 6;
  localparam int unsigned STALL_PC  = 0;
  localparam int unsigned STALL_IF  = 1;
  localparam int unsigned STALL_ID  = 2;
  localparam int unsigned STALL_EX  = 3;
  localparam int unsigned STALL_MEM = 4;
  localparam int unsigned STALL_WB  = 5;

  localparam logic [STALL_W-1:0] STALL_NONE     = 6'b000000;
  // Load-use: freeze pc/if/id; EX advances and ID/EX takes a bubble.
  localparam logic [STALL_W-1:0] STALL_LOAD_USE = 6'b000111;
  // Divide: additionally freeze EX so the divide instruction sits there.
  localparam logic [STALL_W-1:0] STALL_DIV      = 6'b001111;

  typedef enum logic {
    StIdle    = 1'b0,
    StDivWait = 1'b1
  } state_e;

  function automatic logic load_use_hazard(
    input logic       ex_is_load,
    input logic       ex_wen,
    input logic [4:0] ex_waddr,
    input logic       id_reg1_read,
    input logic [4:0] id_reg1_addr,
    input logic       id_reg2_read,
    input logic [4:0] id_reg2_addr
  );
    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    return ex_is_load && ex_wen && (ex_waddr != 5'd0) &&
           ((id_reg1_read && (id_reg1_addr == ex_waddr)) ||
            (id_reg2_read && (id_reg2_addr == ex_waddr)));
  endfunction

endpackage

// File: rtl/pipe_ctrl_div_watchdog.sv
// div_watchdog: cycle counter bounding how long the controller waits on the divider.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   i_clear      - synchronous clear to 0 (priority over enable)
//   i_enable     - count up by one this cycle
//   o_terminal   - count has reached TERMINAL
module pipe_ctrl_div_watchdog #(
  parameter int unsigned TERMINAL = 63
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  logic [7:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 8'd0;
    end else if (i_clear) begin
      r_count <= 8'd0;
    end else if (i_enable) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_terminal = (r_count == 8'(TERMINAL));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall controller for load-use hazards and multi-cycle divides.
// Ports:
//   clk, rst                        - clock, asynchronous active-high reset
//   i_ex_is_load/i_ex_wen/i_ex_waddr - EX-stage load / write info
//   i_id_reg{1,2}_read/_addr        - ID-stage source operands
//   i_ex_div_req                    - EX holds a divide (level)
//   i_div_done                      - divider result valid this cycle
//   i_flush                         - kill the in-flight EX operation
//   o_stall[5:0]                    - hold vector {wb,mem,ex,id,if,pc}
//   o_div_start / o_div_abort       - one-cycle divider launch / cancel pulses
//   o_div_timeout                   - sticky watchdog-expiry flag
//   o_stall_cycles                  - count of cycles with the ID stage held
// DIV_TIMEOUT must lie in 2..255.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DIV_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_ex_is_load,
  input  logic                i_ex_wen,
  input  logic [4:0]          i_ex_waddr,
  input  logic                i_id_reg1_read,
  input  logic                i_id_reg2_read,
  input  logic [4:0]          i_id_reg1_addr,
  input  logic [4:0]          i_id_reg2_addr,
  input  logic                i_ex_div_req,
  input  logic                i_div_done,
  input  logic                i_flush,
  output logic [STALL_W-1:0]  o_stall,
  output logic                o_div_start,
  output logic                o_div_abort,
  output logic                o_div_timeout,
  output logic [31:0]         o_stall_cycles
);

  state_e              r_state, w_state_next;
  logic                r_div_timeout;
  logic [31:0]         r_stall_cycles;
  logic [STALL_W-1:0]  w_stall;
  logic                w_div_start, w_div_abort;
  logic                w_wd_clear, w_wd_enable, w_wd_terminal;
  logic                w_set_timeout;
  logic                w_hazard;

  assign w_hazard = load_use_hazard(i_ex_is_load, i_ex_wen, i_ex_waddr,
                                    i_id_reg1_read, i_id_reg1_addr,
                                    i_id_reg2_read, i_id_reg2_addr);

  pipe_ctrl_div_watchdog #(
    .TERMINAL (DIV_TIMEOUT - 1)
  ) u_div_watchdog (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_wd_clear),
    .i_enable   (w_wd_enable),
    .o_terminal (w_wd_terminal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= StIdle;
      r_div_timeout  <= 1'b0;
      r_stall_cycles <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (w_set_timeout) begin
        r_div_timeout <= 1'b1;
      end
      if (w_stall[STALL_ID]) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_stall       = STALL_NONE;
    w_div_start   = 1'b0;
    w_div_abort   = 1'b0;
    w_wd_clear    = 1'b0;
    w_wd_enable   = 1'b0;
    w_set_timeout = 1'b0;
    // Outputs are held quiet while reset is asserted; the divider is reset by
    // the same signal, so no abort pulse is needed.
    if (!rst) begin
      unique case (r_state)
        StIdle: begin
          if (i_ex_div_req && !i_flush) begin
            w_div_start  = 1'b1;
            w_stall      = STALL_DIV;
            w_wd_clear   = 1'b1;
            w_state_next = StDivWait;
          end else if (w_hazard) begin
            w_stall = STALL_LOAD_USE;
          end
        end
        StDivWait: begin
          if (i_flush) begin
            w_div_abort  = 1'b1;
            w_state_next = StIdle;
          end else if (i_div_done) begin
            // Release EX so the divide retires at this edge.
            w_state_next = StIdle;
          end else if (w_wd_terminal) begin
            w_div_abort   = 1'b1;
            w_set_timeout = 1'b1;
            w_state_next  = StIdle;
          end else begin
            w_stall     = STALL_DIV;
            w_wd_enable = 1'b1;
          end
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  assign o_stall        = w_stall;
  assign o_div_start    = w_div_start;
  assign o_div_abort    = w_div_abort;
  assign o_div_timeout  = r_div_timeout;
  assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
// u_dut uses the default timeout; u_dut8 uses DIV_TIMEOUT=8 and has its own
// divide request/done inputs so the watchdog scenario can run independently.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ex_is_load, ex_wen;
  logic [4:0] ex_waddr;
  logic       id_reg1_read, id_reg2_read;
  logic [4:0] id_reg1_addr, id_reg2_addr;
  logic       ex_div_req, div_done, flush;
  logic       ex_div_req8, div_done8;

  logic [5:0]  stall, stall8;
  logic        div_start, div_abort, div_timeout;
  logic        div_start8, div_abort8, div_timeout8;
  logic [31:0] stall_cycles, stall_cycles8;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] exp_sc;

  always #5 clk = ~clk;

  pipe_ctrl u_dut (
    .clk            (clk),
    .rst            (rst),
    .i_ex_is_load   (ex_is_load),
    .i_ex_wen       (ex_wen),
    .i_ex_waddr     (ex_waddr),
    .i_id_reg1_read (id_reg1_read),
    .i_id_reg2_read (id_reg2_read),
    .i_id_reg1_addr (id_reg1_addr),
    .i_id_reg2_addr (id_reg2_addr),
    .i_ex_div_req   (ex_div_req),
    .i_div_done     (div_done),
    .i_flush        (flush),
    .o_stall        (stall),
    .o_div_start    (div_start),
    .o_div_abort    (div_abort),
    .o_div_timeout  (div_timeout),
    .o_stall_cycles (stall_cycles)
  );

  pipe_ctrl #(
    .DIV_TIMEOUT (8)
  ) u_dut8 (
    .clk            (clk),
    .rst            (rst),
    .i_ex_is_load   (ex_is_load),
    .i_ex_wen       (ex_wen),
    .i_ex_waddr     (ex_waddr),
    .i_id_reg1_read (id_reg1_read),
    .i_id_reg2_read (id_reg2_read),
    .i_id_reg1_addr (id_reg1_addr),
    .i_id_reg2_addr (id_reg2_addr),
    .i_ex_div_req   (ex_div_req8),
    .i_div_done     (div_done8),
    .i_flush        (flush),
    .o_stall        (stall8),
    .o_div_start    (div_start8),
    .o_div_abort    (div_abort8),
    .o_div_timeout  (div_timeout8),
    .o_stall_cycles (stall_cycles8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge (inputs change here).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ex_is_load = 1'b0; ex_wen = 1'b0; ex_waddr = 5'd0;
    id_reg1_read = 1'b0; id_reg2_read = 1'b0;
    id_reg1_addr = 5'd0; id_reg2_addr = 5'd0;
    ex_div_req = 1'b0; div_done = 1'b0; flush = 1'b0;
    ex_div_req8 = 1'b0; div_done8 = 1'b0;

    // Reset state
    #2;
    chk("rst_stall", {26'd0, stall}, 32'd0);
    chk("rst_start", {31'd0, div_start}, 32'd0);
    chk("rst_timeout", {31'd0, div_timeout}, 32'd0);
    chk("rst_sc", stall_cycles, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Load-use on source 2, present for one cycle
    cyc();
    ex_is_load = 1'b1; ex_wen = 1'b1; ex_waddr = 5'd5;
    id_reg2_read = 1'b1; id_reg2_addr = 5'd5;
    #1 chk("lu_r2_stall", {26'd0, stall}, 32'h07);
    chk("lu_r2_nostart", {31'd0, div_start}, 32'd0);
    cyc();
    ex_is_load = 1'b0;
    #1 chk("lu_r2_clear", {26'd0, stall}, 32'd0);
    chk("lu_sc1", stall_cycles, 32'd1);

    // Destination x0 never hazards
    ex_is_load = 1'b1; ex_waddr = 5'd0; id_reg2_addr = 5'd0;
    #1 chk("lu_x0", {26'd0, stall}, 32'd0);

    // Source 1 match, then same without read enable, then without wen
    cyc();
    id_reg2_read = 1'b0; ex_waddr = 5'd7; id_reg1_read = 1'b1; id_reg1_addr = 5'd7;
    #1 chk("lu_r1_stall", {26'd0, stall}, 32'h07);
    cyc();
    id_reg1_read = 1'b0;
    #1 chk("lu_r1_noread", {26'd0, stall}, 32'd0);
    id_reg1_read = 1'b1; ex_wen = 1'b0;
    #1 chk("lu_nowen", {26'd0, stall}, 32'd0);
    cyc();
    ex_is_load = 1'b0; ex_wen = 1'b0; id_reg1_read = 1'b0;
    exp_sc = 32'd2;
    #1 chk("lu_sc2", stall_cycles, exp_sc);

    // Divide with done at cycle 10
    cyc();
    ex_div_req = 1'b1;
    #1 chk("div_c0_start", {31'd0, div_start}, 32'd1);
    chk("div_c0_stall", {26'd0, stall}, 32'h0F);
    for (int i = 1; i <= 9; i++) begin
      cyc();
      #1 chk($sformatf("div_c%0d_stall", i), {26'd0, stall}, 32'h0F);
      chk($sformatf("div_c%0d_nostart", i), {31'd0, div_start}, 32'd0);
    end
    cyc();
    div_done = 1'b1;
    #1 chk("div_c10_stall", {26'd0, stall}, 32'd0);
    chk("div_c10_noabort", {31'd0, div_abort}, 32'd0);
    chk("div_c10_nostart", {31'd0, div_start}, 32'd0);
    cyc();
    div_done = 1'b0; ex_div_req = 1'b0;
    exp_sc = exp_sc + 32'd10;
    #1 chk("div_c11_idle_stall", {26'd0, stall}, 32'd0);
    chk("div_c11_sc", stall_cycles, exp_sc);

    // Priority: divide wins over load-use in IDLE
    ex_div_req = 1'b1; ex_is_load = 1'b1; ex_wen = 1'b1; ex_waddr = 5'd3;
    id_reg1_read = 1'b1; id_reg1_addr = 5'd3;
    #1 chk("prio_stall", {26'd0, stall}, 32'h0F);
    chk("prio_start", {31'd0, div_start}, 32'd1);
    cyc();
    ex_is_load = 1'b0; ex_wen = 1'b0; id_reg1_read = 1'b0;
    div_done = 1'b1;
    #1 chk("prio_done_stall", {26'd0, stall}, 32'd0);
    cyc();
    div_done = 1'b0; ex_div_req = 1'b0;

    // Flush in IDLE suppresses the launch
    ex_div_req = 1'b1; flush = 1'b1;
    #1 chk("idle_flush_nostart", {31'd0, div_start}, 32'd0);
    cyc();
    flush = 1'b0;
    #1 chk("idle_flush_relaunch", {31'd0, div_start}, 32'd1);

    // Flush + done together at cycle 3 of the divide
    cyc();
    cyc();
    cyc();
    flush = 1'b1; div_done = 1'b1;
    #1 chk("flush_abort", {31'd0, div_abort}, 32'd1);
    chk("flush_stall", {26'd0, stall}, 32'd0);
    chk("flush_nostart", {31'd0, div_start}, 32'd0);
    cyc();
    flush = 1'b0; div_done = 1'b0; ex_div_req = 1'b0;
    #1 chk("flush_idle_stall", {26'd0, stall}, 32'd0);
    chk("flush_noabort", {31'd0, div_abort}, 32'd0);
    chk("flush_timeout", {31'd0, div_timeout}, 32'd0);

    // Watchdog expiry on the DIV_TIMEOUT=8 instance
    ex_div_req8 = 1'b1;
    #1 chk("to_c0_start", {31'd0, div_start8}, 32'd1);
    for (int i = 1; i <= 7; i++) begin
      cyc();
      #1 chk($sformatf("to_c%0d_stall", i), {26'd0, stall8}, 32'h0F);
      chk($sformatf("to_c%0d_noabort", i), {31'd0, div_abort8}, 32'd0);
    end
    cyc();
    #1 chk("to_c8_abort", {31'd0, div_abort8}, 32'd1);
    chk("to_c8_stall", {26'd0, stall8}, 32'd0);
    chk("to_c8_nostart", {31'd0, div_start8}, 32'd0);
    chk("to_c8_flag_pre", {31'd0, div_timeout8}, 32'd0);
    cyc();
    #1 chk("to_c9_flag", {31'd0, div_timeout8}, 32'd1);
    chk("to_c9_relaunch", {31'd0, div_start8}, 32'd1);
    cyc();
    div_done8 = 1'b1;
    #1 chk("to_c10_done_stall", {26'd0, stall8}, 32'd0);
    cyc();
    div_done8 = 1'b0; ex_div_req8 = 1'b0;
    #1 chk("to_sticky", {31'd0, div_timeout8}, 32'd1);
    chk("to_default_unaffected", {31'd0, div_timeout}, 32'd0);

    // Asynchronous reset mid-divide
    cyc();
    ex_div_req = 1'b1;
    cyc();
    #1 chk("ar_wait_stall", {26'd0, stall}, 32'h0F);
    #1 rst = 1'b1;
    #1 chk("ar_stall", {26'd0, stall}, 32'd0);
    chk("ar_noabort", {31'd0, div_abort}, 32'd0);
    chk("ar_nostart", {31'd0, div_start}, 32'd0);
    chk("ar_sc", stall_cycles, 32'd0);
    chk("ar_timeout8", {31'd0, div_timeout8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ex_div_req = 1'b0;
    cyc();
    ex_div_req = 1'b1;
    #1 chk("ar_idle_start", {31'd0, div_start}, 32'd1);
    cyc();
    div_done = 1'b1;
    cyc();
    div_done = 1'b0; ex_div_req = 1'b0;
    #1 chk("ar_sc_after", stall_cycles, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
